// File: rtl/seq_bit_feeder.sv
// seq_bit_feeder: parallel-to-serial feeder for a serial sequence detector.
// Accepts WIDTH-bit words over valid/ready and double-buffers them: one
// shift register plus one holding register. Emits one bit per clock with a
// qualifying strobe. Back-to-back words give a gap-free bitstream.
//
// Ports:
//   clk, rst        clock (rising edge), async active-low reset
//   clr             sync clear of shifter and holding register (keeps words_sent)
//   s_data/s_valid  input word and its valid
//   s_ready         word can be accepted (= holding register empty)
//   msb_first       bit order, sampled when a word enters the shifter
//   bit_out         serial bit (registered)
//   bit_valid       bit_out carries a data bit (registered)
//   busy            shifter or holding register occupied
//   words_sent      count of fully emitted words, wraps
module seq_bit_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             msb_first,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [CW-1:0]    cnt_q;
  logic [15:0]      words_sent_q;
  logic             bit_out_q;
  logic             bit_valid_q;

  // Put the word into emit order: the bit to send first lands at index 0,
  // so the shifter always shifts right regardless of msb_first.
  function automatic logic [WIDTH-1:0] emit_order(input logic [WIDTH-1:0] w,
                                                  input logic msb);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = msb ? w[WIDTH-1-i] : w[i];
    return r;
  endfunction

  logic             last_bit;
  logic             accept;
  logic             load_hold;
  logic             load_new;
  logic [WIDTH-1:0] load_word;

  assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST);
  assign accept    = s_valid && !hold_full_q;
  // Holding register has priority at the last-bit edge; s_ready is low then,
  // so an accept and a hold drain never coincide.
  assign load_hold = last_bit && hold_full_q;
  assign load_new  = accept && ((state_q == IDLE) || last_bit);
  assign load_word = emit_order(load_hold ? hold_q : s_data, msb_first);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      cnt_q        <= '0;
      words_sent_q <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      if (last_bit) words_sent_q <= words_sent_q + 16'd1;

      if (load_hold || load_new) begin
        sh_q        <= load_word;
        cnt_q       <= '0;
        state_q     <= SHIFT;
        bit_out_q   <= load_word[0];
        bit_valid_q <= 1'b1;
      end else if (last_bit) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        bit_out_q   <= 1'b0;
        bit_valid_q <= 1'b0;
      end else if (state_q == SHIFT) begin
        sh_q      <= sh_q >> 1;
        cnt_q     <= cnt_q + CW'(1);
        bit_out_q <= sh_q[1];
      end

      if (load_hold) begin
        hold_full_q <= 1'b0;
      end else if (accept && !load_new) begin
        hold_q      <= s_data;
        hold_full_q <= 1'b1;
      end
    end
  end

  assign s_ready    = !hold_full_q;
  assign busy       = (state_q == SHIFT) || hold_full_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_seq_bit_feeder.sv
module tb_seq_bit_feeder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic         msb_first;
  logic         bit_out;
  logic         bit_valid;
  logic         busy;
  logic [15:0]  words_sent;

  seq_bit_feeder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .msb_first(msb_first), .bit_out(bit_out),
    .bit_valid(bit_valid), .busy(busy), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: the bits still to emit for the current word, in order,
  // plus an optional held word. Front of cur is what bit_out shows now.
  bit          cur[$];
  bit          hv;
  logic [W-1:0] hw;
  logic [15:0] ws;

  task automatic m_load(input logic [W-1:0] w, input logic m);
    for (int k = 0; k < W; k++) cur.push_back(m ? w[W-1-k] : w[k]);
  endtask

  task automatic m_reset();
    cur.delete(); hv = 0; hw = '0; ws = '0;
  endtask

  task automatic m_edge(input logic v, input logic [W-1:0] d, input logic m, input logic c);
    bit acc, used;
    if (c) begin cur.delete(); hv = 0; return; end
    acc = v && !hv;
    used = 0;
    if (cur.size() > 0) begin
      void'(cur.pop_front());
      if (cur.size() == 0) ws++;
    end
    if (cur.size() == 0) begin
      if (hv) begin m_load(hw, m); hv = 0; end
      else if (acc) begin m_load(d, m); used = 1; end
    end
    if (acc && !used) begin hv = 1; hw = d; end
  endtask

  task automatic m_check(input string tag);
    bit ev;
    ev = cur.size() > 0;
    chk({tag, ".bit_valid"}, 32'(bit_valid), 32'(ev));
    chk({tag, ".bit_out"}, 32'(bit_out), ev ? 32'(cur[0]) : 32'd0);
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(!hv));
    chk({tag, ".busy"}, 32'(busy), 32'(ev || hv));
    chk({tag, ".words_sent"}, 32'(words_sent), 32'(ws));
  endtask

  // One clock: drive inputs (called at a negedge), update model at the edge,
  // check outputs at the following negedge.
  task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                      input logic m, input logic c);
    s_valid = v; s_data = d; msb_first = m; clr = c;
    @(posedge clk);
    m_edge(v, d, m, c);
    @(negedge clk);
    m_check(tag);
  endtask

  logic [W-1:0] got;
  int           nb;
  int           nvalid;
  logic [W-1:0] words3 [3];
  int           idx;
  bit           tog;

  initial begin
    words3[0] = 8'h0E; words3[1] = 8'h70; words3[2] = 8'hFF;
    rst = 1'b0; clr = 1'b0; s_valid = 1'b1; s_data = 8'hA5; msb_first = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst.s_ready", 32'(s_ready), 32'd1);
    chk("rst.bit_valid", 32'(bit_valid), 32'd0);
    chk("rst.words_sent", 32'(words_sent), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (3) step("idle", 1'b0, 8'h00, 1'b1, 1'b0);

    // Single word, MSB first
    step("e5m", 1'b1, 8'hE5, 1'b1, 1'b0);
    got = '0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (bit_valid) begin got = {got[W-2:0], bit_out}; nb++; end
      step("e5m", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("e5m.seq", 32'(got), 32'h E5);
    chk("e5m.nbits", 32'(nb), 32'd8);
    chk("e5m.words", 32'(words_sent), 32'd1);

    // LSB first, toggling msb_first mid-word must not matter
    step("e5l", 1'b1, 8'hE5, 1'b0, 1'b0);
    got = '0; nb = 0; tog = 0;
    for (int i = 0; i < 10; i++) begin
      if (bit_valid) begin got = {got[W-2:0], bit_out}; nb++; end
      tog = ~tog;
      step("e5l", 1'b0, 8'h00, tog, 1'b0);
    end
    chk("e5l.seq", 32'(got), 32'h A7);
    chk("e5l.nbits", 32'(nb), 32'd8);

    // Streaming three words back to back
    idx = 0; nvalid = 0; got = '0;
    for (int i = 0; i < 40; i++) begin
      bit rd;
      rd = s_ready;
      if (bit_valid) nvalid++;
      if (idx < 3) begin
        step("strm", 1'b1, words3[idx], 1'b1, 1'b0);
        if (rd) idx++;
      end else begin
        step("strm", 1'b0, 8'h00, 1'b1, 1'b0);
      end
    end
    chk("strm.nvalid", 32'(nvalid), 32'd24);
    chk("strm.words", 32'(words_sent), 32'd5);

    // clr at bit 3 of word 1 with word 2 held
    step("clr", 1'b1, 8'h3C, 1'b1, 1'b0);
    step("clr", 1'b1, 8'hC3, 1'b1, 1'b0);
    step("clr", 1'b0, 8'h00, 1'b1, 1'b0);
    step("clr", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("clr.held", 32'(s_ready), 32'd0);
    step("clr", 1'b1, 8'h55, 1'b1, 1'b1);
    chk("clr.bit_valid", 32'(bit_valid), 32'd0);
    chk("clr.busy", 32'(busy), 32'd0);
    chk("clr.words", 32'(words_sent), 32'd5);
    step("clr", 1'b1, 8'h81, 1'b1, 1'b0);
    chk("clr.restart", 32'(bit_out), 32'd1);
    repeat (9) step("clr", 1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-word: outputs return to reset values at once
    step("amid", 1'b1, 8'hFF, 1'b1, 1'b0);
    step("amid", 1'b1, 8'hFF, 1'b1, 1'b0);
    rst = 1'b0; #1;
    m_reset();
    chk("amid.bit_valid", 32'(bit_valid), 32'd0);
    chk("amid.busy", 32'(busy), 32'd0);
    chk("amid.words", 32'(words_sent), 32'd0);
    chk("amid.s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));
    end
    repeat (20) step("drain", 1'b0, 8'h00, 1'b0, 1'b0);

    // Counter wrap
    force dut.words_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.words_sent_q;
    ws = 16'hFFFF;
    step("wrap", 1'b1, 8'h96, 1'b1, 1'b0);
    repeat (9) step("wrap", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap.zero", 32'(words_sent), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
